// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: in-order queue of predicted branches, out-of-order resolution, in-order
// retirement driving predictor training, GHR restore and redirect. Optional: BRU_PERF_CNT_EN.
module branch_resolve_unit #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned PHT_ADDRESS = 9,
    parameter int unsigned DEPTH       = 8,
    localparam int unsigned TAG_W      = $clog2(DEPTH)
) (
    input  logic                   CLK,
    input  logic                   reset,
    input  logic                   alloc_valid,
    output logic                   alloc_ready,
    output logic [TAG_W-1:0]       alloc_tag,
    input  logic [XLEN-1:0]        alloc_pc,
    input  logic [PHT_ADDRESS-1:0] alloc_pht_index,
    input  logic [PHT_ADDRESS-1:0] alloc_ghr_snap,
    input  logic                   alloc_pred_taken,
    input  logic [XLEN-1:0]        alloc_pred_target,
    input  logic                   alloc_is_ret,
    input  logic                   res_valid,
    input  logic [TAG_W-1:0]       res_tag,
    input  logic                   res_taken,
    input  logic [XLEN-1:0]        res_target,
    output logic                   update_pht,
    output logic                   update_btb,
    output logic                   actual_taken,
    output logic [PHT_ADDRESS-1:0] rb_pht_index,
    output logic [XLEN-1:0]        ex_pc,
    output logic [XLEN-1:0]        actual_target_address,
    output logic                   ex_is_ret,
    output logic                   restore_ghr,
    output logic [PHT_ADDRESS-1:0] ghr_restore_val,
`ifdef BRU_PERF_CNT_EN
    output logic [31:0]            perf_retired,
    output logic [31:0]            perf_mispred,
`endif
    output logic                   redirect_valid,
    output logic [XLEN-1:0]        redirect_pc
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {StEmpty, StPending, StResolved} entry_state_e;

    entry_state_e           r_state      [DEPTH];
    logic [XLEN-1:0]        r_pc         [DEPTH];
    logic [PHT_ADDRESS-1:0] r_pht_index  [DEPTH];
    logic [PHT_ADDRESS-2:0] r_ghr_snap   [DEPTH];
    logic                   r_pred_taken [DEPTH];
    logic [XLEN-1:0]        r_pred_target[DEPTH];
    logic                   r_is_ret     [DEPTH];
    logic                   r_taken      [DEPTH];
    logic [XLEN-1:0]        r_target     [DEPTH];

    logic [TAG_W-1:0] r_head;
    logic [TAG_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic                   r_update_pht;
    logic                   r_update_btb;
    logic                   r_actual_taken;
    logic [PHT_ADDRESS-1:0] r_rb_pht_index;
    logic [XLEN-1:0]        r_ex_pc;
    logic [XLEN-1:0]        r_actual_target;
    logic                   r_ex_is_ret;
    logic                   r_restore_ghr;
    logic [PHT_ADDRESS-1:0] r_ghr_restore_val;
    logic                   r_redirect_valid;
    logic [XLEN-1:0]        r_redirect_pc;

    logic                   w_retire;
    logic                   w_mispred;
    logic                   w_alloc;
    logic                   w_resolve;
    logic                   w_tgt_diff;
    logic [TAG_W-1:0]       w_head_inc;
    logic                   w_hd_taken;
    logic [XLEN-1:0]        w_hd_target;
    logic                   w_unused_snap_msb;

    // The snapshot MSB is shifted out by the restore and never needs storing.
    assign w_unused_snap_msb = alloc_ghr_snap[PHT_ADDRESS-1];

    assign alloc_ready = (r_count != CNT_W'(DEPTH));
    assign alloc_tag   = r_tail;

    assign w_head_inc  = r_head + TAG_W'(1);
    assign w_hd_taken  = r_taken[r_head];
    assign w_hd_target = r_target[r_head];
    assign w_tgt_diff  = (w_hd_target != r_pred_target[r_head]);
    assign w_retire    = (r_state[r_head] == StResolved);
    assign w_mispred   = w_retire &&
                         ((w_hd_taken != r_pred_taken[r_head]) || (w_hd_taken && w_tgt_diff));
    // A mispredict retire flushes everything, so same-cycle alloc/resolve are discarded.
    assign w_alloc     = alloc_valid && alloc_ready && !w_mispred;
    assign w_resolve   = res_valid && (r_state[res_tag] == StPending) && !w_mispred;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) r_state[i] <= StEmpty;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (w_mispred) begin
            for (int i = 0; i < DEPTH; i++) r_state[i] <= StEmpty;
            r_head  <= w_head_inc;
            r_tail  <= w_head_inc;
            r_count <= '0;
        end else begin
            if (w_resolve) r_state[res_tag] <= StResolved;
            if (w_retire) begin
                r_state[r_head] <= StEmpty;
                r_head          <= w_head_inc;
            end
            if (w_alloc) begin
                r_state[r_tail] <= StPending;
                r_tail          <= r_tail + TAG_W'(1);
            end
            case ({w_alloc, w_retire})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload is only read at head once resolved, so it needs no reset.
    always_ff @(posedge CLK) begin
        if (w_alloc) begin
            r_pc[r_tail]          <= alloc_pc;
            r_pht_index[r_tail]   <= alloc_pht_index;
            r_ghr_snap[r_tail]    <= alloc_ghr_snap[PHT_ADDRESS-2:0];
            r_pred_taken[r_tail]  <= alloc_pred_taken;
            r_pred_target[r_tail] <= alloc_pred_target;
            r_is_ret[r_tail]      <= alloc_is_ret;
        end
        if (w_resolve) begin
            r_taken[res_tag]  <= res_taken;
            r_target[res_tag] <= res_target;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_update_pht      <= 1'b0;
            r_update_btb      <= 1'b0;
            r_actual_taken    <= 1'b0;
            r_rb_pht_index    <= '0;
            r_ex_pc           <= '0;
            r_actual_target   <= '0;
            r_ex_is_ret       <= 1'b0;
            r_restore_ghr     <= 1'b0;
            r_ghr_restore_val <= '0;
            r_redirect_valid  <= 1'b0;
            r_redirect_pc     <= '0;
        end else begin
            r_update_pht      <= w_retire && !r_is_ret[r_head];
            r_update_btb      <= w_retire && w_hd_taken && (!r_pred_taken[r_head] || w_tgt_diff);
            r_actual_taken    <= w_retire && w_hd_taken;
            r_rb_pht_index    <= w_retire ? r_pht_index[r_head] : '0;
            r_ex_pc           <= w_retire ? r_pc[r_head] : '0;
            r_actual_target   <= w_retire ? w_hd_target : '0;
            r_ex_is_ret       <= w_retire && r_is_ret[r_head];
            r_restore_ghr     <= w_mispred;
            r_ghr_restore_val <= w_mispred ? {r_ghr_snap[r_head], w_hd_taken} : '0;
            r_redirect_valid  <= w_mispred;
            r_redirect_pc     <= !w_mispred ? '0 :
                                 w_hd_taken ? w_hd_target : r_pc[r_head] + XLEN'(4);
        end
    end

    assign update_pht            = r_update_pht;
    assign update_btb            = r_update_btb;
    assign actual_taken          = r_actual_taken;
    assign rb_pht_index          = r_rb_pht_index;
    assign ex_pc                 = r_ex_pc;
    assign actual_target_address = r_actual_target;
    assign ex_is_ret             = r_ex_is_ret;
    assign restore_ghr           = r_restore_ghr;
    assign ghr_restore_val       = r_ghr_restore_val;
    assign redirect_valid        = r_redirect_valid;
    assign redirect_pc           = r_redirect_pc;

`ifdef BRU_PERF_CNT_EN
    logic [31:0] r_perf_retired;
    logic [31:0] r_perf_mispred;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_perf_retired <= '0;
            r_perf_mispred <= '0;
        end else begin
            if (w_retire)  r_perf_retired <= r_perf_retired + 32'd1;
            if (w_mispred) r_perf_mispred <= r_perf_mispred + 32'd1;
        end
    end

    assign perf_retired = r_perf_retired;
    assign perf_mispred = r_perf_mispred;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit; inputs driven and outputs sampled
// on the falling clock edge.
module tb_branch_resolve_unit;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned PHTA  = 9;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned TAG_W = 3;

    logic             CLK = 1'b0;
    logic             reset = 1'b0;
    logic             alloc_valid = 1'b0;
    logic             alloc_ready;
    logic [TAG_W-1:0] alloc_tag;
    logic [XLEN-1:0]  alloc_pc = '0;
    logic [PHTA-1:0]  alloc_pht_index = '0;
    logic [PHTA-1:0]  alloc_ghr_snap = '0;
    logic             alloc_pred_taken = 1'b0;
    logic [XLEN-1:0]  alloc_pred_target = '0;
    logic             alloc_is_ret = 1'b0;
    logic             res_valid = 1'b0;
    logic [TAG_W-1:0] res_tag = '0;
    logic             res_taken = 1'b0;
    logic [XLEN-1:0]  res_target = '0;
    logic             update_pht;
    logic             update_btb;
    logic             actual_taken;
    logic [PHTA-1:0]  rb_pht_index;
    logic [XLEN-1:0]  ex_pc;
    logic [XLEN-1:0]  actual_target_address;
    logic             ex_is_ret;
    logic             restore_ghr;
    logic [PHTA-1:0]  ghr_restore_val;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_pc;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    branch_resolve_unit #(
        .XLEN        (XLEN),
        .PHT_ADDRESS (PHTA),
        .DEPTH       (DEPTH)
    ) u_dut (
        .CLK                   (CLK),
        .reset                 (reset),
        .alloc_valid           (alloc_valid),
        .alloc_ready           (alloc_ready),
        .alloc_tag             (alloc_tag),
        .alloc_pc              (alloc_pc),
        .alloc_pht_index       (alloc_pht_index),
        .alloc_ghr_snap        (alloc_ghr_snap),
        .alloc_pred_taken      (alloc_pred_taken),
        .alloc_pred_target     (alloc_pred_target),
        .alloc_is_ret          (alloc_is_ret),
        .res_valid             (res_valid),
        .res_tag               (res_tag),
        .res_taken             (res_taken),
        .res_target            (res_target),
        .update_pht            (update_pht),
        .update_btb            (update_btb),
        .actual_taken          (actual_taken),
        .rb_pht_index          (rb_pht_index),
        .ex_pc                 (ex_pc),
        .actual_target_address (actual_target_address),
        .ex_is_ret             (ex_is_ret),
        .restore_ghr           (restore_ghr),
        .ghr_restore_val       (ghr_restore_val),
        .redirect_valid        (redirect_valid),
        .redirect_pc           (redirect_pc)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic do_reset();
        alloc_valid = 1'b0;
        res_valid   = 1'b0;
        reset       = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic drive_alloc(input logic [31:0] pc, input logic [PHTA-1:0] snap,
                               input logic pt, input logic [31:0] ptgt, input logic ret);
        alloc_valid       = 1'b1;
        alloc_pc          = pc;
        alloc_pht_index   = pc[PHTA+1:2];
        alloc_ghr_snap    = snap;
        alloc_pred_taken  = pt;
        alloc_pred_target = ptgt;
        alloc_is_ret      = ret;
    endtask

    task automatic do_alloc(input logic [31:0] pc, input logic [PHTA-1:0] snap,
                            input logic pt, input logic [31:0] ptgt, input logic ret);
        drive_alloc(pc, snap, pt, ptgt, ret);
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic do_resolve(input logic [TAG_W-1:0] tag, input logic tk,
                              input logic [31:0] tgt);
        res_valid  = 1'b1;
        res_tag    = tag;
        res_taken  = tk;
        res_target = tgt;
        tick();
        res_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_ready", 32'(alloc_ready), 32'd1);
        check("rst_tag", 32'(alloc_tag), 32'd0);
        check("rst_upd_pht", 32'(update_pht), 32'd0);
        check("rst_redirect", 32'(redirect_valid), 32'd0);

        // Single correctly predicted not-taken branch
        do_alloc(32'h100, 9'h000, 1'b0, 32'h0, 1'b0);
        do_resolve(3'd0, 1'b0, 32'h0);
        check("t1_no_early_pulse", 32'(update_pht), 32'd0);
        tick();
        check("t1_upd_pht", 32'(update_pht), 32'd1);
        check("t1_upd_btb", 32'(update_btb), 32'd0);
        check("t1_restore", 32'(restore_ghr), 32'd0);
        check("t1_redirect", 32'(redirect_valid), 32'd0);
        check("t1_ex_pc", ex_pc, 32'h100);
        check("t1_pht_idx", 32'(rb_pht_index), 32'h040);
        tick();
        check("t1_pulse_end", 32'(update_pht), 32'd0);

        // Out-of-order resolution, in-order retirement
        do_reset();
        do_alloc(32'h400, 9'h000, 1'b0, 32'h0, 1'b0);
        do_alloc(32'h404, 9'h000, 1'b0, 32'h0, 1'b0);
        do_alloc(32'h408, 9'h000, 1'b0, 32'h0, 1'b0);
        check("t2_tail", 32'(alloc_tag), 32'd3);
        do_resolve(3'd2, 1'b0, 32'h0);
        check("t2_hold_for_head", 32'(update_pht), 32'd0);
        do_resolve(3'd0, 1'b0, 32'h0);
        do_resolve(3'd1, 1'b0, 32'h0);
        check("t2_ret0", ex_pc, 32'h400);
        tick();
        check("t2_ret1", ex_pc, 32'h404);
        tick();
        check("t2_ret2", ex_pc, 32'h408);
        check("t2_ret2_valid", 32'(update_pht), 32'd1);
        tick();
        check("t2_drained", 32'(update_pht), 32'd0);

        // Target mispredict with flush; same-cycle alloc and resolve must be dropped
        do_reset();
        do_alloc(32'h200, 9'h0A5, 1'b1, 32'h300, 1'b0);
        do_alloc(32'h210, 9'h000, 1'b0, 32'h0, 1'b0);
        do_alloc(32'h220, 9'h000, 1'b0, 32'h0, 1'b0);
        do_resolve(3'd1, 1'b0, 32'h0);
        do_resolve(3'd0, 1'b1, 32'h340);
        drive_alloc(32'h999, 9'h000, 1'b0, 32'h0, 1'b0);
        res_valid  = 1'b1;
        res_tag    = 3'd2;
        res_taken  = 1'b0;
        tick();
        alloc_valid = 1'b0;
        res_valid   = 1'b0;
        check("t3_upd_btb", 32'(update_btb), 32'd1);
        check("t3_restore", 32'(restore_ghr), 32'd1);
        check("t3_ghr_val", 32'(ghr_restore_val), 32'h14B);
        check("t3_redirect", 32'(redirect_valid), 32'd1);
        check("t3_redirect_pc", redirect_pc, 32'h340);
        check("t3_act_tgt", actual_target_address, 32'h340);
        check("t3_next_tag", 32'(alloc_tag), 32'd1);
        tick();
        tick();
        check("t3_flushed", 32'(update_pht), 32'd0);
        do_resolve(3'd2, 1'b0, 32'h0);
        tick();
        check("t3_flushed_res", 32'(update_pht), 32'd0);
        do_alloc(32'h500, 9'h000, 1'b0, 32'h0, 1'b0);
        do_resolve(3'd1, 1'b0, 32'h0);
        tick();
        check("t3_post_flush_pc", ex_pc, 32'h500);

        // Predicted taken, actually not taken at the top of the address space
        do_reset();
        do_alloc(32'hFFFF_FFFC, 9'h1FF, 1'b1, 32'h1000, 1'b0);
        do_resolve(3'd0, 1'b0, 32'h0);
        tick();
        check("t4_redirect", 32'(redirect_valid), 32'd1);
        check("t4_redirect_pc", redirect_pc, 32'h0000_0000);
        check("t4_upd_btb", 32'(update_btb), 32'd0);
        check("t4_ghr_val", 32'(ghr_restore_val), 32'h1FE);
        check("t4_act_taken", 32'(actual_taken), 32'd0);

        // Fill, refuse when full, wrap the tail
        do_reset();
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t5_tag%0d", i), 32'(alloc_tag), 32'(i));
            do_alloc(32'h600 + 32'(4 * i), 9'h000, 1'b0, 32'h0, 1'b0);
        end
        check("t5_full", 32'(alloc_ready), 32'd0);
        check("t5_tail_wrap", 32'(alloc_tag), 32'd0);
        do_alloc(32'hBAD, 9'h000, 1'b0, 32'h0, 1'b0);
        check("t5_still_full", 32'(alloc_ready), 32'd0);
        do_resolve(3'd0, 1'b0, 32'h0);
        check("t5_full_until_retire", 32'(alloc_ready), 32'd0);
        tick();
        check("t5_ret_pc", ex_pc, 32'h600);
        check("t5_ready", 32'(alloc_ready), 32'd1);
        do_alloc(32'h700, 9'h000, 1'b0, 32'h0, 1'b0);
        check("t5_tag_after", 32'(alloc_tag), 32'd1);
        check("t5_full_again", 32'(alloc_ready), 32'd0);
        do_resolve(3'd1, 1'b0, 32'h0);
        tick();
        check("t5_ret1_pc", ex_pc, 32'h604);

        // Return with wrong target, then reset mid-queue while a pulse is live
        do_reset();
        do_alloc(32'h700, 9'h003, 1'b1, 32'h800, 1'b1);
        do_alloc(32'h704, 9'h000, 1'b0, 32'h0, 1'b0);
        do_resolve(3'd0, 1'b1, 32'h900);
        tick();
        check("t6_upd_pht", 32'(update_pht), 32'd0);
        check("t6_is_ret", 32'(ex_is_ret), 32'd1);
        check("t6_redirect", 32'(redirect_valid), 32'd1);
        check("t6_redirect_pc", redirect_pc, 32'h900);
        check("t6_ghr_val", 32'(ghr_restore_val), 32'h007);
        do_alloc(32'h710, 9'h000, 1'b0, 32'h0, 1'b0);
        do_alloc(32'h714, 9'h000, 1'b0, 32'h0, 1'b0);
        do_resolve(3'd1, 1'b0, 32'h0);
        tick();
        check("t6_pre_rst_pc", ex_pc, 32'h710);
        reset = 1'b0;
        #1;
        check("t6_rst_upd_pht", 32'(update_pht), 32'd0);
        check("t6_rst_ex_pc", ex_pc, 32'h0);
        check("t6_rst_tag", 32'(alloc_tag), 32'd0);
        check("t6_rst_ready", 32'(alloc_ready), 32'd1);
        @(negedge CLK);
        reset = 1'b1;
        do_resolve(3'd2, 1'b0, 32'h0);
        tick();
        check("t6_rst_cleared", 32'(update_pht), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Return-path partner of the prediction stage.
- Tracks every predicted branch in an in-order circular queue.
- Accepts out-of-order resolutions from EX, then retires in program order.
- At retirement, drives the PHT/BTB update, GHR restore and PC redirect signals back into prediction, and flushes younger in-flight branches on a mispredict.

Parameters:
- XLEN, 32, address/data width.
- PHT_ADDRESS, 9, PHT index width; also the GHR width.
- DEPTH, 8, queue entries; must be a power of 2. TAG_W = $clog2(DEPTH) is derived, not a user parameter.

Ports:
- CLK  input  1  clock
- reset  input  1  asynchronous, active-low reset
- alloc_valid  input  1  prediction stage allocates a branch entry
- alloc_ready  output  1  queue not full
- alloc_tag  output  TAG_W  tag assigned to the allocating branch (current tail)
- alloc_pc  input  XLEN  branch PC
- alloc_pht_index  input  PHT_ADDRESS  PHT index used at prediction
- alloc_ghr_snap  input  PHT_ADDRESS  GHR value before this branch was shifted in
- alloc_pred_taken  input  1  predicted direction
- alloc_pred_target  input  XLEN  predicted target
- alloc_is_ret  input  1  branch is a return
- res_valid  input  1  EX resolution valid
- res_tag  input  TAG_W  resolved entry tag
- res_taken  input  1  actual direction
- res_target  input  XLEN  actual target
- update_pht  output  1  PHT train pulse
- update_btb  output  1  BTB write pulse
- actual_taken  output  1  retired direction
- rb_pht_index  output  PHT_ADDRESS  PHT index to train
- ex_pc  output  XLEN  retired branch PC
- actual_target_address  output  XLEN  retired actual target
- ex_is_ret  output  1  retired branch is a return
- restore_ghr  output  1  GHR restore pulse
- ghr_restore_val  output  PHT_ADDRESS  corrected GHR value
- redirect_valid  output  1  fetch redirect pulse
- redirect_pc  output  XLEN  correct fetch PC

Behaviour:
- Reset (reset=0, asynchronous): head=tail=0, count=0, all entries EMPTY, all outputs 0. alloc_ready reflects count=0, i.e. 1.
- Queue structure: circular buffer with per-entry state EMPTY/PENDING/RESOLVED. head and tail wrap modulo DEPTH.
- alloc_ready = (count != DEPTH). alloc_tag = tail.
- Allocate when alloc_valid && alloc_ready: entry[tail] becomes PENDING and stores all alloc_* fields; tail++.
- Resolve when res_valid and entry[res_tag] is PENDING: store taken/target, state becomes RESOLVED at the edge. A resolve to an EMPTY or RESOLVED entry is ignored.
- Retire: when entry[head] is RESOLVED, it retires that cycle (max 1 per cycle), head++, count--. An entry resolved at edge N retires no earlier than cycle N+1.
- Outputs are registered 1-cycle pulses, valid the cycle after retire:
  - actual_taken, rb_pht_index, ex_pc, actual_target_address, ex_is_ret loaded from the entry.
  - update_pht = !is_ret.
  - update_btb = taken && (!pred_taken || target != pred_target).
- mispredict = (taken != pred_taken) || (taken && target != pred_target).
- On mispredict retire:
  - restore_ghr=1, ghr_restore_val = {ghr_snap[PHT_ADDRESS-2:0], taken}.
  - redirect_valid=1, redirect_pc = taken ? target : pc+4 (XLEN wrap).
  - Flush: all entries become EMPTY, tail = head+1, count = 0.
  - Any allocate in the same cycle is dropped.
  - A resolve in the same cycle to a younger tag is dropped.
- count changes: simultaneous allocate and non-mispredict retire leaves count unchanged. Allocation while full is refused; there is no bypass.
- Latency: resolve at edge N → retire at cycle N+1 → pulses at N+2.

Optional Feature:
- Macro BRU_PERF_CNT_EN.
- Defined: adds 32-bit outputs perf_retired and perf_mispred. They count retires and mispredict retires, wrap on overflow, and reset to 0.
- Undefined: ports and counters are absent; no other behaviour changes.

Test Plan:
- Reset then allocate pc=0x100, pred NT; resolve NT → pulse two cycles later: update_pht=1, update_btb=0, restore_ghr=0, redirect_valid=0, ex_pc=0x100.
- Allocate tags 0,1,2; resolve 2, then 0, then 1 → retirements in order 0,1,2; ex_pc sequence matches allocation order.
- Allocate pc=0x200, pred T target 0x300, snap=0x0A5; resolve T target 0x340 → update_btb=1, restore_ghr=1, ghr_restore_val=0x14B, redirect_pc=0x340; following queued entries flushed; next alloc_tag = old head+1.
- Predicted T, actual NT at pc=0xFFFFFFFC → redirect_pc=0x00000000 (wrap), update_btb=0.
- Allocate 8 without resolving → alloc_ready=0, a 9th allocate is ignored; retire one → alloc_ready=1; tail wraps 7→0.
- Return entry (is_ret=1), mispredicted target → update_pht=0, ex_is_ret=1, redirect_valid=1. Assert reset mid-queue → all outputs 0 immediately, count=0.
